keypad_code_entry: RTL and testbench
====================================

Name: keypad_code_entry

Overview:
- Keypad front-end that drives the password-lock interface.
- Debounces raw bit keys '0' and '1' plus ENTER, CLEAR and MODE keys, and assembles 4-bit codes MSB first.
- Issues the lock's one-cycle submit strobes and generates the timed change-mode hold, so the lock never receives raw buttons.
- Sits between the physical keypad and the lock. Consumes the lock's alarm output to block entry during lockout.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required before a key level change is accepted.
HOLD_CYCLES, 8, cycles change_mode_button is held high. Must be >=6 to satisfy the lock's hold requirement.
TIMEOUT_CYCLES, 64, idle cycles without an accepted key event before a partial entry is abandoned.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
key_zero  input  1  raw key, bit value 0
key_one  input  1  raw key, bit value 1
key_enter  input  1  raw key, submit current code
key_clear  input  1  raw key, discard current code
key_mode  input  1  raw key, start password-change sequence
lock_alarm  input  1  lock alarm level, synchronous to clk
entered_password  output  4  code presented to lock, held between submits
submit  output  1  one-cycle strobe, entered_password valid
change_mode_button  output  1  timed hold level to lock
master_key_input  output  4  master key code, held between commits
master_key_submit  output  1  one-cycle strobe
new_password_input  output  4  new password code, held between commits
new_password_submit  output  1  one-cycle strobe, coincident with master_key_submit
digit_count  output  3  bits collected in the current field, 0..4
entry_error  output  1  one-cycle pulse on rejected or abandoned entry
entry_state  output  3  FSM state code

Behaviour:
- Reset: all outputs 0, FSM in IDLE, shift buffers 0, debounced key levels 0, counters 0.
- Key input path:
  - Each raw key passes through a 2-flop synchronizer and then a debouncer.
  - The debounced level flips after DEBOUNCE_CYCLES consecutive synchronized samples differ from it.
  - A press event is the rising edge of the debounced level, one cycle wide.
  - Latency from a raw key going high (and staying high) to its event: DEBOUNCE_CYCLES+2 to DEBOUNCE_CYCLES+3 cycles.
  - Release produces no event. A key toggling faster than DEBOUNCE_CYCLES produces no event.
- Simultaneous events are resolved by priority: CLEAR > ENTER > MODE > ONE > ZERO. Only the highest is processed that cycle; the others are dropped.
- Bit entry: buffer <= {buffer[2:0], bit}; digit_count increments. A bit arriving at count 4 is discarded and pulses entry_error.
- Timeout counter:
  - Clears on every accepted event and on every state entry.
  - Counts only in ENTRY, MKEY and NEWPW.
  - On reaching TIMEOUT_CYCLES: entry_error pulse, buffers and digit_count cleared, go to IDLE.
- States (entry_state code):
  - IDLE(000):
    - bit -> ENTRY with count=1.
    - MODE -> HOLD.
    - ENTER -> entry_error pulse, stay in IDLE.
    - CLEAR -> no effect.
  - ENTRY(001):
    - bits shift in.
    - ENTER with count==4 -> SUBMIT.
    - ENTER with count<4 -> entry_error pulse, clear, IDLE.
    - CLEAR -> clear, IDLE, no error.
    - MODE ignored.
  - SUBMIT(010): single cycle. entered_password <= buffer in the same cycle submit=1. Then buffer and count cleared, go to IDLE. entered_password retains its value afterwards.
  - HOLD(011):
    - change_mode_button=1 for exactly HOLD_CYCLES cycles, then 0, go to MKEY.
    - All key events are discarded.
  - MKEY(100): collects 4 bits as in ENTRY. ENTER with count==4 stores the master code, clears count, go to NEWPW. Short ENTER or timeout -> entry_error pulse, IDLE. CLEAR -> IDLE, no error.
  - NEWPW(101): same rules as MKEY. ENTER with count==4 -> COMMIT.
  - COMMIT(110): single cycle.
    - master_key_input and new_password_input are updated.
    - master_key_submit=1 and new_password_submit=1 in the same cycle.
    - Then go to IDLE. The block does not check the master key; the lock does.
  - LOCKED(111):
    - Entered from any state except SUBMIT and COMMIT the cycle after lock_alarm is sampled high. SUBMIT and COMMIT finish their cycle first, then go to LOCKED.
    - change_mode_button is forced to 0, buffers and count are cleared, all events are discarded.
    - The cycle after lock_alarm is sampled low -> IDLE.
- Reset asserted mid-operation: immediate return to reset values. Any strobe in flight is suppressed.
- Strobes are never asserted for more than one cycle. Strobes never assert outside SUBMIT or COMMIT.

Test Plan:
- Reset, then release reset with no keys pressed for 100 cycles -> all outputs 0, entry_state=000, no strobes.
- Press 1,0,1,0 then ENTER (each key held 8 cycles, 8 cycles apart) -> exactly one submit pulse with entered_password=1010; digit_count returns to 0; entry_state back to 000.
- Press 1,1 then ENTER -> one entry_error pulse, no submit; a 5-bit sequence 1,0,1,0,1 -> error on the 5th bit, ENTER then submits 1010.
- Press MODE -> change_mode_button high exactly 8 cycles; then enter 1111+ENTER and 0101+ENTER -> master_key_input=1111 and new_password_input=0101, with master_key_submit and new_password_submit high together for one cycle.
- Enter 2 bits, then raise lock_alarm -> entry_state=111, key presses ignored; drop lock_alarm -> IDLE with digit_count=0; then 0101+ENTER submits 0101.
- Enter 3 bits, then wait 64 cycles -> entry_error pulse, IDLE, no submit. Toggle key_one every cycle for 20 cycles -> no bit accepted, digit_count stays 0.

Source files
------------

// File: rtl/keypad_code_entry.sv
// Keypad front-end for the password lock: synchronizes and debounces five raw keys,
// assembles 4-bit codes MSB first and issues the lock's submit strobes and change-mode hold.
module keypad_code_entry #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 8,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_zero,
    input  logic       key_one,
    input  logic       key_enter,
    input  logic       key_clear,
    input  logic       key_mode,
    input  logic       lock_alarm,
    output logic [3:0] entered_password,
    output logic       submit,
    output logic       change_mode_button,
    output logic [3:0] master_key_input,
    output logic       master_key_submit,
    output logic [3:0] new_password_input,
    output logic       new_password_submit,
    output logic [2:0] digit_count,
    output logic       entry_error,
    output logic [2:0] entry_state
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam int K_ZERO  = 0;
    localparam int K_ONE   = 1;
    localparam int K_ENTER = 2;
    localparam int K_CLEAR = 3;
    localparam int K_MODE  = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        ENTRY  = 3'b001,
        SUBMIT = 3'b010,
        HOLD   = 3'b011,
        MKEY   = 3'b100,
        NEWPW  = 3'b101,
        COMMIT = 3'b110,
        LOCKED = 3'b111
    } state_t;

    state_t          state, state_next;
    logic [4:0]      raw_keys;
    logic [4:0]      sync1, sync2, deb, key_evt, flip;
    logic [DW-1:0]   deb_cnt [5];
    logic [3:0]      buffer, buffer_next, master_code, master_next;
    logic [2:0]      count_next;
    logic [3:0]      pw_next, mk_next, np_next;
    logic            error_next;
    logic [HW-1:0]   hold_cnt, hold_next;
    logic [TW-1:0]   timer, timer_next;
    logic            ev_clear, ev_enter, ev_mode, ev_bit, bit_val, any_evt;
    logic            collecting;

    assign raw_keys = {key_mode, key_clear, key_enter, key_one, key_zero};

    // A key flips its debounced level on the last of DEBOUNCE_CYCLES differing samples
    always_comb begin
        flip = '0;
        for (int i = 0; i < 5; i++) begin
            flip[i] = (sync2[i] != deb[i]) && (deb_cnt[i] == DW'(DEBOUNCE_CYCLES - 1));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1   <= '0;
            sync2   <= '0;
            deb     <= '0;
            key_evt <= '0;
            for (int i = 0; i < 5; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync1   <= raw_keys;
            sync2   <= sync1;
            key_evt <= flip & sync2;
            for (int i = 0; i < 5; i++) begin
                if (flip[i]) begin
                    deb[i]     <= ~deb[i];
                    deb_cnt[i] <= '0;
                end else if (sync2[i] != deb[i]) begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    // Only the highest-priority event of a cycle survives
    assign any_evt  = |key_evt;
    assign ev_clear = key_evt[K_CLEAR];
    assign ev_enter = key_evt[K_ENTER] & ~key_evt[K_CLEAR];
    assign ev_mode  = key_evt[K_MODE] & ~key_evt[K_CLEAR] & ~key_evt[K_ENTER];
    assign bit_val  = key_evt[K_ONE];
    assign ev_bit   = (key_evt[K_ONE] | key_evt[K_ZERO]) & ~key_evt[K_CLEAR]
                      & ~key_evt[K_ENTER] & ~key_evt[K_MODE];

    assign collecting = (state == ENTRY) || (state == MKEY) || (state == NEWPW);

    always_comb begin
        state_next  = state;
        buffer_next = buffer;
        count_next  = digit_count;
        master_next = master_code;
        pw_next     = entered_password;
        mk_next     = master_key_input;
        np_next     = new_password_input;
        error_next  = 1'b0;
        hold_next   = '0;
        timer_next  = '0;

        if (lock_alarm && state != SUBMIT && state != COMMIT && state != LOCKED) begin
            state_next  = LOCKED;
            buffer_next = '0;
            count_next  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ev_bit) begin
                        state_next  = ENTRY;
                        buffer_next = {3'b000, bit_val};
                        count_next  = 3'd1;
                    end else if (ev_mode) begin
                        state_next = HOLD;
                    end else if (ev_enter) begin
                        error_next = 1'b1;
                    end
                end
                ENTRY, MKEY, NEWPW: begin
                    if (ev_clear) begin
                        state_next  = IDLE;
                        buffer_next = '0;
                        count_next  = '0;
                    end else if (ev_enter) begin
                        if (digit_count == 3'd4) begin
                            if (state == ENTRY) begin
                                state_next = SUBMIT;
                                pw_next    = buffer;
                            end else if (state == MKEY) begin
                                state_next  = NEWPW;
                                master_next = buffer;
                                buffer_next = '0;
                                count_next  = '0;
                            end else begin
                                state_next = COMMIT;
                                mk_next    = master_code;
                                np_next    = buffer;
                            end
                        end else begin
                            state_next  = IDLE;
                            error_next  = 1'b1;
                            buffer_next = '0;
                            count_next  = '0;
                        end
                    end else if (ev_bit) begin
                        if (digit_count == 3'd4) begin
                            error_next = 1'b1;
                        end else begin
                            buffer_next = {buffer[2:0], bit_val};
                            count_next  = digit_count + 3'd1;
                        end
                    end else if (!any_evt && timer == TW'(TIMEOUT_CYCLES - 1)) begin
                        state_next  = IDLE;
                        error_next  = 1'b1;
                        buffer_next = '0;
                        count_next  = '0;
                    end
                end
                SUBMIT, COMMIT: begin
                    state_next  = lock_alarm ? LOCKED : IDLE;
                    buffer_next = '0;
                    count_next  = '0;
                end
                HOLD: begin
                    if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
                        state_next = MKEY;
                    end else begin
                        hold_next = hold_cnt + 1'b1;
                    end
                end
                LOCKED: begin
                    if (!lock_alarm) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end

        // Idle timer restarts on any key event and on every state change
        if (state_next == state && !any_evt && collecting) begin
            timer_next = timer + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            buffer             <= '0;
            digit_count        <= '0;
            master_code        <= '0;
            entered_password   <= '0;
            master_key_input   <= '0;
            new_password_input <= '0;
            entry_error        <= 1'b0;
            hold_cnt           <= '0;
            timer              <= '0;
        end else begin
            state              <= state_next;
            buffer             <= buffer_next;
            digit_count        <= count_next;
            master_code        <= master_next;
            entered_password   <= pw_next;
            master_key_input   <= mk_next;
            new_password_input <= np_next;
            entry_error        <= error_next;
            hold_cnt           <= hold_next;
            timer              <= timer_next;
        end
    end

    assign submit              = (state == SUBMIT);
    assign master_key_submit   = (state == COMMIT);
    assign new_password_submit = (state == COMMIT);
    assign change_mode_button  = (state == HOLD);
    assign entry_state         = state;

endmodule

// File: tb/tb_keypad_code_entry.sv
// Randomized bench for keypad_code_entry: key presses are scored against an event-level
// model of the entry rules, with a cycle monitor for strobe widths and the change-mode hold.
module tb_keypad_code_entry;

    localparam int DEBOUNCE_CYCLES = 4;
    localparam int HOLD_CYCLES     = 8;
    localparam int TIMEOUT_CYCLES  = 64;

    localparam logic [4:0] K_ZERO  = 5'b00001;
    localparam logic [4:0] K_ONE   = 5'b00010;
    localparam logic [4:0] K_ENTER = 5'b00100;
    localparam logic [4:0] K_CLEAR = 5'b01000;
    localparam logic [4:0] K_MODE  = 5'b10000;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_zero, key_one, key_enter, key_clear, key_mode, lock_alarm;
    logic [3:0] entered_password, master_key_input, new_password_input;
    logic       submit, change_mode_button, master_key_submit, new_password_submit;
    logic [2:0] digit_count, entry_state;
    logic       entry_error;

    keypad_code_entry #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .HOLD_CYCLES    (HOLD_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .key_zero           (key_zero),
        .key_one            (key_one),
        .key_enter          (key_enter),
        .key_clear          (key_clear),
        .key_mode           (key_mode),
        .lock_alarm         (lock_alarm),
        .entered_password   (entered_password),
        .submit             (submit),
        .change_mode_button (change_mode_button),
        .master_key_input   (master_key_input),
        .master_key_submit  (master_key_submit),
        .new_password_input (new_password_input),
        .new_password_submit(new_password_submit),
        .digit_count        (digit_count),
        .entry_error        (entry_error),
        .entry_state        (entry_state)
    );

    always #5 clk = ~clk;

    int testsRun = 0;
    int testsFailed = 0;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        testsRun++;
        if (observed != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Pulse monitor: counts strobes and checks their width and the hold length
    int subSeen = 0, errSeen = 0, commitSeen = 0, holdSeen = 0, holdWidth = 0;
    logic prevSub = 1'b0, prevCommit = 1'b0, prevErr = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            holdWidth = 0;
            prevSub = 1'b0;
            prevCommit = 1'b0;
            prevErr = 1'b0;
        end else begin
            if (submit) begin
                subSeen++;
                checkOutput("submit_width", int'(prevSub), 0);
                checkOutput("submit_state", int'(entry_state), 2);
            end
            if (master_key_submit || new_password_submit) begin
                commitSeen++;
                checkOutput("commit_pair", int'({master_key_submit, new_password_submit}), 3);
                checkOutput("commit_width", int'(prevCommit), 0);
            end
            if (entry_error) begin
                errSeen++;
                checkOutput("error_width", int'(prevErr), 0);
            end
            if (change_mode_button) begin
                holdWidth++;
            end else if (holdWidth != 0) begin
                holdSeen++;
                checkOutput("hold_width", holdWidth, HOLD_CYCLES);
                holdWidth = 0;
            end
            prevSub = submit;
            prevCommit = master_key_submit;
            prevErr = entry_error;
        end
    end

    // Reference model: mode 0 idle, 1 entry, 2 master key, 3 new password, 4 locked
    int mMode = 0;
    int mBits[$];
    int mMaster = 0;
    int expPw = 0, expMk = 0, expNp = 0;
    int expSub = 0, expErr = 0, expCommit = 0, expHold = 0;

    function automatic int bitsValue();
        int v = 0;
        foreach (mBits[i]) v = v * 2 + mBits[i];
        return v;
    endfunction

    function automatic int stateCode(input int mode);
        case (mode)
            1: return 1;
            2: return 4;
            3: return 5;
            4: return 7;
            default: return 0;
        endcase
    endfunction

    task automatic modelAbort(input bit isError);
        if (isError) expErr++;
        mBits.delete();
        mMode = 0;
    endtask

    task automatic modelKey(input logic [4:0] keys);
        if (mMode == 4 || keys == 5'b0) return;
        if (keys & K_CLEAR) begin
            if (mMode != 0) modelAbort(1'b0);
        end else if (keys & K_ENTER) begin
            if (mMode == 0) begin
                expErr++;
            end else if (mBits.size() != 4) begin
                modelAbort(1'b1);
            end else if (mMode == 1) begin
                expSub++;
                expPw = bitsValue();
                modelAbort(1'b0);
            end else if (mMode == 2) begin
                mMaster = bitsValue();
                mBits.delete();
                mMode = 3;
            end else begin
                expCommit++;
                expMk = mMaster;
                expNp = bitsValue();
                modelAbort(1'b0);
            end
        end else if (keys & K_MODE) begin
            if (mMode == 0) begin
                expHold++;
                mMode = 2;
            end
        end else begin
            if (mMode == 0) begin
                mMode = 1;
                mBits.push_back((keys & K_ONE) != 0 ? 1 : 0);
            end else if (mBits.size() == 4) begin
                expErr++;
            end else begin
                mBits.push_back((keys & K_ONE) != 0 ? 1 : 0);
            end
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, "_state"}, int'(entry_state), stateCode(mMode));
        checkOutput({tag, "_count"}, int'(digit_count), mBits.size());
        checkOutput({tag, "_submits"}, subSeen, expSub);
        checkOutput({tag, "_errors"}, errSeen, expErr);
        checkOutput({tag, "_commits"}, commitSeen, expCommit);
        checkOutput({tag, "_holds"}, holdSeen, expHold);
        checkOutput({tag, "_password"}, int'(entered_password), expPw);
        checkOutput({tag, "_master"}, int'(master_key_input), expMk);
        checkOutput({tag, "_newpw"}, int'(new_password_input), expNp);
        checkOutput({tag, "_button"}, int'(change_mode_button), 0);
    endtask

    task automatic driveKeys(input logic [4:0] keys);
        {key_mode, key_clear, key_enter, key_one, key_zero} = keys;
    endtask

    // One key press: held 8 cycles, released 12, then scored
    task automatic applyStimulus(input logic [4:0] keys, input string tag);
        @(posedge clk); #1;
        driveKeys(keys);
        repeat (8) @(posedge clk);
        #1 driveKeys(5'b0);
        repeat (12) @(posedge clk);
        #1;
        modelKey(keys);
        checkAll(tag);
    endtask

    task automatic enterCode(input logic [3:0] code, input string tag);
        for (int i = 3; i >= 0; i--) applyStimulus(code[i] ? K_ONE : K_ZERO, tag);
    endtask

    task automatic idleTimeout(input string tag);
        repeat (TIMEOUT_CYCLES + 36) @(posedge clk);
        #1;
        if (mMode >= 1 && mMode <= 3) modelAbort(1'b1);
        checkAll(tag);
    endtask

    task automatic alarmEpisode(input logic [4:0] keys, input string tag);
        @(posedge clk); #1;
        lock_alarm = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        mMode = 4;
        mBits.delete();
        checkOutput({tag, "_locked"}, int'(entry_state), 7);
        applyStimulus(keys, tag);
        lock_alarm = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        mMode = 0;
        checkAll({tag, "_release"});
    endtask

    logic [4:0] k;
    int r;

    initial begin
        reset = 1'b1;
        lock_alarm = 1'b0;
        driveKeys(5'b0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        checkAll("reset");
        checkOutput("reset_error", int'(entry_error), 0);

        enterCode(4'b1010, "bits");
        applyStimulus(K_ENTER, "submit1010");
        checkOutput("submit1010_value", int'(entered_password), 4'b1010);

        applyStimulus(K_ONE, "short");
        applyStimulus(K_ONE, "short");
        applyStimulus(K_ENTER, "short_enter");
        enterCode(4'b1010, "five");
        applyStimulus(K_ONE, "fifth_bit");
        applyStimulus(K_ENTER, "five_enter");
        checkOutput("five_value", int'(entered_password), 4'b1010);

        applyStimulus(K_MODE, "mode");
        enterCode(4'b1111, "mkey");
        applyStimulus(K_ENTER, "mkey_enter");
        enterCode(4'b0101, "newpw");
        applyStimulus(K_ENTER, "commit");
        checkOutput("commit_master", int'(master_key_input), 4'b1111);
        checkOutput("commit_newpw", int'(new_password_input), 4'b0101);

        applyStimulus(K_ZERO, "pre_alarm");
        applyStimulus(K_ONE, "pre_alarm");
        alarmEpisode(K_ONE, "alarm");
        enterCode(4'b0101, "post_alarm");
        applyStimulus(K_ENTER, "post_alarm_enter");
        checkOutput("post_alarm_value", int'(entered_password), 4'b0101);

        enterCode(4'b0110, "timeout_bits");
        applyStimulus(K_CLEAR, "clear");
        applyStimulus(K_ONE, "timeout_bits");
        applyStimulus(K_ONE, "timeout_bits");
        applyStimulus(K_ZERO, "timeout_bits");
        idleTimeout("timeout");

        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) begin
            key_one = ~key_one;
            @(posedge clk); #1;
        end
        key_one = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        checkAll("toggle");

        for (int step = 0; step < 200; step++) begin
            r = $urandom_range(0, 99);
            if (mBits.size() == 4 && r < 40) k = K_ENTER;
            else if (r < 55) k = ($urandom_range(0, 1) != 0) ? K_ONE : K_ZERO;
            else if (r < 63) k = K_ENTER;
            else if (r < 68) k = K_CLEAR;
            else if (r < 74) k = K_MODE;
            else if (r < 84) k = 5'(1 << $urandom_range(0, 4)) | 5'(1 << $urandom_range(0, 4));
            else if (r < 93) k = ($urandom_range(0, 1) != 0) ? K_ONE : K_ZERO;
            else if (r < 96) k = 5'b0;
            else k = 5'b11111;
            if (k == 5'b0) idleTimeout("rand_timeout");
            else if (k == 5'b11111) alarmEpisode(5'(1 << $urandom_range(0, 4)), "rand_alarm");
            else applyStimulus(k, "rand");
        end

        applyStimulus(K_ONE, "pre_reset");
        applyStimulus(K_ZERO, "pre_reset");
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mMode = 0;
        mBits.delete();
        expPw = 0;
        expMk = 0;
        expNp = 0;
        checkAll("mid_reset");
        reset = 1'b0;
        enterCode(4'b0011, "after_reset");
        applyStimulus(K_ENTER, "after_reset_enter");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
